aq_djpeg_ycbcr_reader: RTL and testbench
========================================

// Module: aq_djpeg_ycbcr_reader
// PURPOSE
//  Read-side sequencer for the decoder's double-banked YCbCr MCU buffer. Waits for a full MCU bank,
//  walks the 16x16 MCU in raster order, and issues Y and CbCr read addresses. Captures the 1-cycle-latency
//  read data into a small FIFO and presents one Y/Cb/Cr pixel per beat on a valid/ready stream to
//  colour conversion. Releases the bank with a one-cycle DataOutReadNext once all 256 pixels are captured.
// PARAMETERS
//  FIFO_DEPTH  4  output FIFO entries; power of 2, >=2; 4 sustains 1 pixel/clk
// PORTS
//  clk                 in   1  clock, all logic on posedge
//  rst                 in   1  asynchronous, active-low reset
//  DataInit            in   1  sync clear: FSM to S_IDLE, FIFO flushed, counters 0
//  JpegComp            in   3  1 = greyscale (Cb/Cr forced to 0), 3 = 4:2:0 colour
//  DataOutEnable       in   1  buffer has a complete unread MCU bank
//  DataOutAddressY     out  8  luma index {y[3:0],x[3:0]}
//  DataOutAddressCbCr  out  8  same index as DataOutAddressY (buffer decimates to 4:2:0)
//  DataOutRead         out  1  read strobe; data valid on DataOutY/Cb/Cr the following cycle
//  DataOutReadNext     out  1  1-cycle pulse, releases current read bank
//  DataOutY/Cb/Cr      in   9  read data from buffer
//  PixValid            out  1  FIFO head valid
//  PixReady            in   1  downstream accepts when PixValid&PixReady
//  PixY/PixCb/PixCr    out  9  pixel components
//  PixX/PixRow         out  4  pixel column / row within MCU
//  PixLast             out  1  high on pixel 255 of the MCU
// BEHAVIOUR
//  Reset: state S_IDLE; all outputs 0; FIFO empty; index 0; inflight 0.
//  FSM: S_IDLE -> S_READ when DataOutEnable=1.
//   S_READ: issue reads until index 255 has been issued -> S_DRAIN.
//   S_DRAIN: wait until inflight=0 -> S_NEXT.
//   S_NEXT: DataOutReadNext=1 for exactly this cycle -> S_WAIT.
//   S_WAIT: one dead cycle so the buffer's bank/enable update settles -> S_IDLE.
//  Read issue: DataOutRead=1 in S_READ iff (fifo_count + inflight) < FIFO_DEPTH.
//   The address equals the current index, which increments by 1 per issued read. No read is issued outside S_READ.
//  inflight: 1-bit flag, set the cycle after an issued read. Capture pushes {Y,Cb,Cr,x,y,last} into the FIFO
//   during the cycle the data is valid; capture and push occur on the same edge.
//  Latency: read issued in cycle t -> pushed at end of t+1 -> PixValid earliest in cycle t+2.
//  FIFO: push and pop in the same cycle are both legal when neither full nor empty, and count is unchanged.
//   The read issue rule guarantees no push when full; a push when full is a design error (assert in sim).
//   Outputs are taken from the registered head; Pix* are held stable while PixValid&!PixReady.
//  Greyscale (JpegComp==1): pushed Cb/Cr are 9'd0 and Y is unchanged. Other JpegComp values are treated as 4:2:0.
//  DataOutReadNext is generated once all 256 pixels are captured, independent of downstream drain.
//   The next MCU may start reading while the FIFO still holds the tail of the previous MCU.
//  DataInit has priority over every transition: FIFO, index, inflight and state are cleared next cycle,
//   and no DataOutReadNext is generated. Asynchronous reset mid-MCU has the same effect immediately.
//  Index wraps 255->0 only via S_NEXT; S_IDLE never issues reads even if DataOutEnable stays high.
// TESTING
//  1 Enable=1, PixReady=1 always -> 256 reads on consecutive cycles, addr 0..255. PixValid from t0+3 for
//    256 cycles. PixLast only on x=15,row=15. One ReadNext pulse at read255+2.
//  2 PixReady toggling 1010.. -> no pixel lost or duplicated. DataOutRead never drives count+inflight above
//    FIFO_DEPTH. Sequence order matches addresses.
//  3 PixReady=0 for 300 cycles -> exactly FIFO_DEPTH reads issued, Pix* stable, no ReadNext. Release ->
//    remaining 256-FIFO_DEPTH pixels follow.
//  4 Two MCUs back-to-back, Enable high throughout -> second read burst starts 3 cycles after ReadNext.
//    Exactly two ReadNext pulses. 512 pixels in order.
//  5 JpegComp=1, buffer model Cb=Cr=9'h155 -> PixCb=PixCr=0 on all 256 pixels, and PixY is unchanged.
//  6 DataInit at read 100 (and rst low at read 200 in a second run) -> next cycle PixValid=0, DataOutRead=0,
//    no ReadNext. A new MCU restarts at addr 0.

Source files
------------

// File: rtl/aq_djpeg_ycbcr_reader.sv
// Read-side sequencer for the double-banked YCbCr MCU buffer: walks a 16x16 MCU in raster
// order, captures the 1-cycle-latency read data and streams pixels through a small FIFO.
module aq_djpeg_ycbcr_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DataInit,
  input  logic [2:0] JpegComp,
  input  logic       DataOutEnable,
  output logic [7:0] DataOutAddressY,
  output logic [7:0] DataOutAddressCbCr,
  output logic       DataOutRead,
  output logic       DataOutReadNext,
  input  logic [8:0] DataOutY,
  input  logic [8:0] DataOutCb,
  input  logic [8:0] DataOutCr,
  output logic       PixValid,
  input  logic       PixReady,
  output logic [8:0] PixY,
  output logic [8:0] PixCb,
  output logic [8:0] PixCr,
  output logic [3:0] PixX,
  output logic [3:0] PixRow,
  output logic       PixLast
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_NEXT, S_WAIT} state_t;

  state_t        state, state_nx;
  logic [7:0]    idx, cap_idx;
  logic          inflight, issue, push, pop, room, grey;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [35:0]   mem [FIFO_DEPTH];
  logic [35:0]   entry, head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (DataOutEnable) state_nx = S_READ;
      S_READ:  if (issue && idx == 8'hFF) state_nx = S_DRAIN;
      // Read 255 was issued last cycle; its capture lands on this edge, so the bank is done.
      S_DRAIN: state_nx = S_NEXT;
      S_NEXT:  state_nx = S_WAIT;
      S_WAIT:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (DataInit) state_nx = S_IDLE;
  end

  always_comb begin
    DataOutRead     = 1'b0;
    DataOutReadNext = 1'b0;
    case (state)
      S_READ:  DataOutRead     = room && !DataInit;
      S_NEXT:  DataOutReadNext = !DataInit;
      default: ;
    endcase
  end

  assign room  = ({1'b0, count} + {{(AW+1){1'b0}}, inflight}) < DEPTH_W;
  assign issue = DataOutRead;
  assign push  = inflight;
  assign pop   = PixValid && PixReady;
  assign grey  = (JpegComp == 3'd1);

  assign DataOutAddressY    = idx;
  assign DataOutAddressCbCr = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      cap_idx  <= '0;
      inflight <= 1'b0;
    end else if (DataInit) begin
      idx      <= '0;
      cap_idx  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) cap_idx <= idx;
      if (issue && idx != 8'hFF) idx <= idx + 8'd1;
      if (state == S_NEXT) idx <= '0;
    end
  end

  assign entry = {DataOutY, grey ? 9'd0 : DataOutCb, grey ? 9'd0 : DataOutCr,
                  cap_idx[3:0], cap_idx[7:4], cap_idx == 8'hFF};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (DataInit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // The issue rule reserves a slot for every read in flight, so a full FIFO never sees a push.
  always @(posedge clk) begin
    if (rst && !DataInit) assert (!(push && count == FULL_CNT));
  end

  assign head     = mem[rd_ptr];
  assign PixValid = (count != '0);
  assign {PixY, PixCb, PixCr, PixX, PixRow, PixLast} = head;

endmodule

// File: tb/tb_aq_djpeg_ycbcr_reader.sv
// Bench for aq_djpeg_ycbcr_reader: buffer model, pixel scoreboard, scenario table and
// hand-written timing, stall, DataInit and mid-MCU reset sequences.
module tb_aq_djpeg_ycbcr_reader;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, DataInit, DataOutEnable, PixReady;
  logic [2:0] JpegComp;
  logic [7:0] DataOutAddressY, DataOutAddressCbCr;
  logic       DataOutRead, DataOutReadNext, PixValid, PixLast;
  logic [8:0] DataOutY, DataOutCb, DataOutCr, PixY, PixCb, PixCr;
  logic [3:0] PixX, PixRow;

  always #5 clk = ~clk;

  aq_djpeg_ycbcr_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .DataInit(DataInit), .JpegComp(JpegComp),
    .DataOutEnable(DataOutEnable), .DataOutAddressY(DataOutAddressY),
    .DataOutAddressCbCr(DataOutAddressCbCr), .DataOutRead(DataOutRead),
    .DataOutReadNext(DataOutReadNext), .DataOutY(DataOutY), .DataOutCb(DataOutCb),
    .DataOutCr(DataOutCr), .PixValid(PixValid), .PixReady(PixReady), .PixY(PixY),
    .PixCb(PixCb), .PixCr(PixCr), .PixX(PixX), .PixRow(PixRow), .PixLast(PixLast)
  );

  typedef struct packed {
    logic [8:0] y, cb, cr;
    logic [3:0] x, row;
    logic       last;
  } pix_t;

  typedef struct {
    logic [2:0] comp;
    int         rmode;
    int         n_mcu;
    int         exp_reads;
    int         exp_nexts;
  } vec_t;

  pix_t sbq[$];
  int vectors = 0, miscompares = 0;
  int cyc_g = 0;
  bit mon_en = 0, grey = 0;
  int reads = 0, pops = 0, nexts = 0, tb_occ = 0;
  logic [7:0] exp_addr = 8'd0;
  logic       pend = 1'b0;
  logic [7:0] pend_addr = 8'd0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [36:0] prev_bus = '0;
  int first_rd, first_vld, rd255, first_next, vld_at_next, n_vld, gap, gap_ref;
  bit gap_armed;

  function automatic logic [8:0] y_of(input logic [7:0] a);
    return {a[0], a} ^ 9'h0C3;
  endfunction
  function automatic logic [8:0] cb_of(input logic [7:0] a);
    return {a[7], ~a};
  endfunction
  function automatic logic [8:0] cr_of(input logic [7:0] a);
    return {1'b0, a} + 9'd200;
  endfunction

  function automatic pix_t exp_pix(input int k, input bit g);
    pix_t p;
    logic [7:0] a;
    a      = 8'(k);
    p.y    = y_of(a);
    p.cb   = g ? 9'd0 : cb_of(a);
    p.cr   = g ? 9'd0 : cr_of(a);
    p.x    = a[3:0];
    p.row  = a[7:4];
    p.last = (k == 255);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_marks();
    first_rd = -1; first_vld = -1; rd255 = -1; first_next = -1;
    vld_at_next = -1; n_vld = 0; gap = -1; gap_armed = 0; gap_ref = 0;
  endtask

  always @(posedge clk) cyc_g++;

  // Buffer model and monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (pend) begin
      DataOutY  = y_of(pend_addr);
      DataOutCb = grey ? 9'h155 : cb_of(pend_addr);
      DataOutCr = grey ? 9'h155 : cr_of(pend_addr);
    end
    pend      = DataOutRead;
    pend_addr = DataOutAddressY;

    if (PixValid) begin
      n_vld++;
      if (first_vld < 0) first_vld = cyc_g;
    end
    if (DataOutRead) begin
      reads++;
      if (first_rd < 0) first_rd = cyc_g;
      if (DataOutAddressY == 8'hFF && rd255 < 0) rd255 = cyc_g;
      if (gap_armed) begin
        gap = cyc_g - gap_ref;
        gap_armed = 0;
      end
    end
    if (DataOutReadNext) begin
      nexts++;
      if (first_next < 0) begin
        first_next  = cyc_g;
        vld_at_next = n_vld;
        gap_armed   = 1;
        gap_ref     = cyc_g;
      end
    end

    if (mon_en) begin
      if (prev_v && !prev_r)
        chk("hold", 64'({PixValid, PixY, PixCb, PixCr, PixX, PixRow, PixLast}), 64'(prev_bus));
      if (DataOutRead) begin
        chk("rd_addr_y", 64'(DataOutAddressY), 64'(exp_addr));
        chk("rd_addr_cbcr", 64'(DataOutAddressCbCr), 64'(exp_addr));
        chk("rd_occupancy", 64'(tb_occ < DEPTH), 64'd1);
        exp_addr = exp_addr + 8'd1;
      end
      if (PixValid && PixReady) begin
        if (sbq.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else chk("pixel", 64'({PixY, PixCb, PixCr, PixX, PixRow, PixLast}), 64'(sbq.pop_front()));
      end
      prev_v   = PixValid;
      prev_r   = PixReady;
      prev_bus = {PixValid, PixY, PixCb, PixCr, PixX, PixRow, PixLast};
    end else begin
      prev_v = 1'b0;
    end
    if (PixValid && PixReady) pops++;
    tb_occ = tb_occ + (DataOutRead ? 1 : 0) - ((PixValid && PixReady) ? 1 : 0);
  end

  // rmode: 0 ready always, 1 toggling 1010.., 2 random, 3 held low 300 cycles then high.
  task automatic run_mcus(input int n, input int rmode, input logic [2:0] comp);
    int cyc, n0, r0;
    grey = (comp == 3'd1);
    JpegComp = comp;
    for (int m = 0; m < n; m++)
      for (int k = 0; k < 256; k++) sbq.push_back(exp_pix(k, comp == 3'd1));
    n0 = nexts; r0 = reads; cyc = 0;
    while ((sbq.size() != 0 || nexts - n0 < n) && cyc < 6000) begin
      case (rmode)
        0:       PixReady = 1'b1;
        1:       PixReady = (cyc % 2 == 0);
        2:       PixReady = 1'($urandom_range(0, 1));
        default: PixReady = (cyc >= 300);
      endcase
      DataOutEnable = (nexts - n0) < n;
      if (rmode == 3 && cyc == 300) begin
        chk("stall_reads", 64'(reads - r0), 64'(DEPTH));
        chk("stall_no_next", 64'(nexts - n0), 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_done", 64'(cyc < 6000), 64'd1);
    DataOutEnable = 1'b0;
    PixReady = 1'b0;
  endtask

  task automatic abort_mid(input int at, input bit use_rst);
    int cnt, n0, r0;
    grey = 0; JpegComp = 3'd3;
    for (int k = 0; k < 256; k++) sbq.push_back(exp_pix(k, 1'b0));
    n0 = nexts; r0 = reads; cnt = 0;
    DataOutEnable = 1'b1; PixReady = 1'b1;
    while (reads - r0 < at && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("abort_reached", 64'(reads - r0 >= at), 64'd1);
    mon_en = 0;
    DataOutEnable = 1'b0;
    if (use_rst) begin
      rst = 1'b0; #1;
    end else begin
      DataInit = 1'b1;
      @(posedge clk); #1;
      DataInit = 1'b0;
    end
    chk("abort_valid", 64'(PixValid), 64'd0);
    chk("abort_read", 64'(DataOutRead), 64'd0);
    chk("abort_addr", 64'(DataOutAddressY), 64'd0);
    if (use_rst) begin
      @(posedge clk); #1;
      rst = 1'b1;
    end
    sbq.delete(); exp_addr = 8'd0; tb_occ = 0;
    mon_en = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_next", 64'(nexts - n0), 64'd0);
    run_mcus(1, 0, 3'd3);
    chk("abort_restart_next", 64'(nexts - n0), 64'd1);
  endtask

  vec_t tbl[6];

  initial begin
    int c0, r0, n0;
    tbl[0] = '{3'd3, 0, 1, 256, 1};
    tbl[1] = '{3'd3, 1, 1, 256, 1};
    tbl[2] = '{3'd1, 0, 1, 256, 1};
    tbl[3] = '{3'd1, 1, 1, 256, 1};
    tbl[4] = '{3'd0, 2, 1, 256, 1};
    tbl[5] = '{3'd3, 2, 2, 512, 2};

    rst = 1'b0; DataInit = 1'b0; JpegComp = 3'd3; DataOutEnable = 1'b0; PixReady = 1'b0;
    DataOutY = '0; DataOutCb = '0; DataOutCr = '0;
    clear_marks();
    #1;
    chk("rst_valid", 64'(PixValid), 64'd0);
    chk("rst_read", 64'(DataOutRead), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_next", 64'(DataOutReadNext), 64'd0);
    chk("rst_addr", 64'({DataOutAddressY, DataOutAddressCbCr}), 64'd0);
    chk("rst_pix", 64'({PixY, PixCb, PixCr, PixX, PixRow, PixLast}), 64'd0);
    rst = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // Full-rate timing and back-to-back MCUs.
    clear_marks();
    c0 = cyc_g; r0 = reads; n0 = nexts;
    run_mcus(2, 0, 3'd3);
    chk("t_first_read", 64'(first_rd), 64'(c0 + 1));
    chk("t_first_valid", 64'(first_vld), 64'(c0 + 3));
    chk("t_read255", 64'(rd255), 64'(c0 + 256));
    chk("t_next_after_255", 64'(first_next), 64'(rd255 + 2));
    chk("t_valid_cycles", 64'(vld_at_next), 64'd256);
    chk("t_restart_gap", 64'(gap), 64'd3);
    chk("t_reads", 64'(reads - r0), 64'd512);
    chk("t_nexts", 64'(nexts - n0), 64'd2);

    for (int i = 0; i < 6; i++) begin
      r0 = reads; n0 = nexts;
      run_mcus(tbl[i].n_mcu, tbl[i].rmode, tbl[i].comp);
      chk("tbl_reads", 64'(reads - r0), 64'(tbl[i].exp_reads));
      chk("tbl_nexts", 64'(nexts - n0), 64'(tbl[i].exp_nexts));
    end

    // Long downstream stall.
    r0 = reads; n0 = nexts;
    run_mcus(1, 3, 3'd3);
    chk("stall_total_reads", 64'(reads - r0), 64'd256);
    chk("stall_total_nexts", 64'(nexts - n0), 64'd1);

    abort_mid(100, 1'b0);
    abort_mid(200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
